// File: rtl/f1_sequencer.sv
// -----------------------------------------------------------------------------
// f1_sequencer
//
// Control sequencer for the Formula One start-lights game. After a start
// button press it lights ten LEDs one at a time, one light every LIGHT_TICKS
// timebase ticks. On the tenth light it freezes a pseudo-random 14-bit delay
// value taken from a free-running LFSR and hands it to the external
// random-delay counter. When that counter reports time_out, all lights go out.
//
// Parameters:
//   LIGHT_TICKS  ticks between successive lights (1..1023)
//   N_MASK       AND-mask applied to the LFSR value before it is loaded into N
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous, active-high reset
//   tick        one-cycle timebase strobe (also the delay counter's trigger)
//   start       synchronised start button level
//   time_out    one-cycle pulse from the delay counter on expiry
//   N           delay value for the delay counter (held while en_lfsr = 0)
//   en_lfsr     1 = LFSR free-running, 0 = N frozen and delay counter counting
//   ledr        light outputs, bit 0 lights first
//   lights_out  one-cycle pulse in the cycle ledr clears after time_out
//   busy        high while a light sequence or the random wait is in progress
// -----------------------------------------------------------------------------
module f1_sequencer #(
  parameter int unsigned LIGHT_TICKS = 500,
  parameter logic [13:0] N_MASK      = 14'h0FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        time_out,
  output logic [13:0] N,
  output logic        en_lfsr,
  output logic [9:0]  ledr,
  output logic        lights_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LIGHTS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] lfsr_q, lfsr_d;
  logic [9:0]  tick_cnt_q, tick_cnt_d;
  logic [9:0]  ledr_q, ledr_d;
  logic [13:0] n_q, n_d;
  logic        en_lfsr_q, en_lfsr_d;
  logic        lights_out_q, lights_out_d;
  logic        busy_q, busy_d;
  logic        start_q, start_d;
  logic        armed_q, armed_d;

  logic        lfsr_fb;
  logic        start_edge;
  logic [10:0] tick_cnt_inc;
  logic [9:0]  ledr_shift;
  logic [13:0] n_masked;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    ledr_d       = ledr_q;
    n_d          = n_q;
    en_lfsr_d    = en_lfsr_q;
    lights_out_d = 1'b0;

    // x^14+x^13+x^12+x^2+1, Fibonacci form, new bit enters at bit 0.
    // Runs every cycle in every state; a non-zero seed never reaches zero.
    lfsr_fb = lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[1];
    lfsr_d  = {lfsr_q[12:0], lfsr_fb};

    // armed_q stays low until start has been seen low at least once since
    // reset, so a button held through reset release is not taken as a press.
    start_d    = start;
    armed_d    = armed_q | ~start;
    start_edge = start & ~start_q & armed_q;

    tick_cnt_inc = {1'b0, tick_cnt_q} + 11'd1;
    ledr_shift   = {ledr_q[8:0], 1'b1};
    n_masked     = lfsr_q & N_MASK;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = LIGHTS;
          tick_cnt_d = '0;
          ledr_d     = '0;
        end
      end

      LIGHTS: begin
        if (tick) begin
          if (tick_cnt_inc == 11'(LIGHT_TICKS)) begin
            tick_cnt_d = '0;
            ledr_d     = ledr_shift;
            // Tenth light: freeze the delay value and hand over to the
            // delay counter in the same cycle. N = 0 is never presented.
            if (ledr_shift == 10'h3FF) begin
              n_d       = (n_masked == '0) ? 14'd1 : n_masked;
              en_lfsr_d = 1'b0;
              state_d   = WAIT;
            end
          end else begin
            tick_cnt_d = tick_cnt_inc[9:0];
          end
        end
      end

      WAIT: begin
        if (time_out) begin
          state_d      = IDLE;
          ledr_d       = '0;
          en_lfsr_d    = 1'b1;
          lights_out_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        ledr_d    = '0;
        en_lfsr_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= 14'h0001;
      tick_cnt_q   <= '0;
      ledr_q       <= '0;
      n_q          <= '0;
      en_lfsr_q    <= 1'b1;
      lights_out_q <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      tick_cnt_q   <= tick_cnt_d;
      ledr_q       <= ledr_d;
      n_q          <= n_d;
      en_lfsr_q    <= en_lfsr_d;
      lights_out_q <= lights_out_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      armed_q      <= armed_d;
    end
  end

  assign N          = n_q;
  assign en_lfsr    = en_lfsr_q;
  assign ledr       = ledr_q;
  assign lights_out = lights_out_q;
  assign busy       = busy_q;

endmodule
